// File: rtl/pattern_match.sv
// pattern_match
//   Byte-stream pattern detector for a UART receive path. A pattern of PAT_LEN
//   bytes is loaded from the stream after an iLOAD command. The block then
//   scans every later byte for occurrences of that pattern, overlapping
//   occurrences included.
//
// Parameters
//   PAT_LEN : number of pattern bytes (2..16)
//   CNT_W   : width of the saturating match counter
//
// Ports
//   clk_s     : clock, all logic on the rising edge
//   rstn_s    : asynchronous active-low reset
//   iDATA     : received byte, qualified by iVALID
//   iVALID    : single-cycle byte strobe
//   iLOAD     : single-cycle command to start capturing a new pattern
//   oMATCH    : registered one-cycle pulse per pattern occurrence
//   oCOUNT    : matches since the last load, saturating
//   oREADY    : a full pattern is held and scanning is active
//   dbg_state : current FSM state (0 EMPTY, 1 LOAD, 2 SCAN)
//
// Handshake: iVALID is a one-cycle strobe with no back-pressure. The block
// consumes every byte on the edge where iVALID=1, so there is no input-side
// ready. oREADY is status only and never throttles the sender.
//
// Build option: define PATTERN_WILDCARD_EN to make pattern byte 8'h3F ('?')
// match any byte. Without it, 8'h3F is an ordinary literal byte.
module pattern_match #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_s,
    input  logic             rstn_s,
    input  logic [7:0]       iDATA,
    input  logic             iVALID,
    input  logic             iLOAD,
    output logic             oMATCH,
    output logic [CNT_W-1:0] oCOUNT,
    output logic             oREADY,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = $clog2(PAT_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);
    localparam logic [IDX_W-1:0] FULL     = IDX_W'(PAT_LEN);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] fill;
    logic [7:0]       pat      [PAT_LEN];
    logic [7:0]       win      [PAT_LEN];

    logic [7:0]       win_next [PAT_LEN];
    logic [IDX_W-1:0] fill_next;
    logic             win_eq;
    logic             match_now;

    assign dbg_state = state;

    function automatic logic byte_eq(input logic [7:0] p, input logic [7:0] w);
`ifdef PATTERN_WILDCARD_EN
        return (p == 8'h3F) || (p == w);
`else
        return p == w;
`endif
    endfunction

    // The match decision looks at the window as it will be after this byte
    // shifts in. That lets oMATCH be registered on the same edge that
    // accepts the final byte.
    always_comb begin
        for (int i = 0; i < PAT_LEN - 1; i++) begin
            win_next[i] = win[i+1];
        end
        win_next[PAT_LEN-1] = iDATA;

        fill_next = (fill == FULL) ? fill : fill + 1'b1;

        win_eq = 1'b1;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (!byte_eq(pat[i], win_next[i])) begin
                win_eq = 1'b0;
            end
        end

        // iLOAD wins over a byte arriving in the same cycle. That byte is
        // discarded, so it can never match.
        match_now = (state == SCAN) && iVALID && !iLOAD &&
                    (fill_next == FULL) && win_eq;
    end

    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            state    <= EMPTY;
            load_idx <= '0;
            fill     <= '0;
            oMATCH   <= 1'b0;
            oCOUNT   <= '0;
            oREADY   <= 1'b0;
            for (int i = 0; i < PAT_LEN; i++) begin
                pat[i] <= 8'h00;
                win[i] <= 8'h00;
            end
        end else begin
            oMATCH <= match_now;
            if (iLOAD) begin
                // A (re)load from any state starts from a clean slate.
                state    <= LOAD;
                load_idx <= '0;
                fill     <= '0;
                oCOUNT   <= '0;
                oREADY   <= 1'b0;
            end else begin
                case (state)
                    EMPTY: begin
                        // Bytes are ignored until a pattern is requested.
                    end
                    LOAD: begin
                        if (iVALID) begin
                            for (int i = 0; i < PAT_LEN; i++) begin
                                if (load_idx == IDX_W'(i)) begin
                                    pat[i] <= iDATA;
                                end
                            end
                            if (load_idx == LAST_IDX) begin
                                state    <= SCAN;
                                load_idx <= '0;
                                oREADY   <= 1'b1;
                            end else begin
                                load_idx <= load_idx + 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (iVALID) begin
                            win  <= win_next;
                            fill <= fill_next;
                            if (match_now && (oCOUNT != {CNT_W{1'b1}})) begin
                                oCOUNT <= oCOUNT + 1'b1;
                            end
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_match.sv
// tb_pattern_match
//   Directed bench for pattern_match. dut_a uses the default parameters.
//   dut_b uses PAT_LEN=2, CNT_W=2 to exercise counter saturation.
module tb_pattern_match;

    // ---------------- clock / reset ----------------
    logic clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    logic rstn_s;

    logic [7:0]  data_a;
    logic        valid_a;
    logic        load_a;
    logic        match_a;
    logic [15:0] count_a;
    logic        ready_a;
    logic [1:0]  state_a;

    logic [7:0]  data_b;
    logic        valid_b;
    logic        load_b;
    logic        match_b;
    logic [1:0]  count_b;
    logic        ready_b;
    logic [1:0]  state_b;

    int errors = 0;
    int checks = 0;

    pattern_match dut_a (
        .clk_s     (clk_s),
        .rstn_s    (rstn_s),
        .iDATA     (data_a),
        .iVALID    (valid_a),
        .iLOAD     (load_a),
        .oMATCH    (match_a),
        .oCOUNT    (count_a),
        .oREADY    (ready_a),
        .dbg_state (state_a)
    );

    pattern_match #(.PAT_LEN(2), .CNT_W(2)) dut_b (
        .clk_s     (clk_s),
        .rstn_s    (rstn_s),
        .iDATA     (data_b),
        .iVALID    (valid_b),
        .iLOAD     (load_b),
        .oMATCH    (match_b),
        .oCOUNT    (count_b),
        .oREADY    (ready_b),
        .dbg_state (state_b)
    );

    // ---------------- drivers ----------------
    task automatic load_pulse_a(input logic with_valid, input logic [7:0] d);
        @(negedge clk_s);
        load_a = 1'b1; valid_a = with_valid; data_a = d;
        @(posedge clk_s); #1;
        load_a = 1'b0; valid_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] d);
        @(negedge clk_s);
        data_a = d; valid_a = 1'b1;
        @(posedge clk_s); #1;
        valid_a = 1'b0;
    endtask

    task automatic idle_a(input int n);
        repeat (n) begin
            @(negedge clk_s);
            data_a = 8'h44;  // garbage while iVALID=0
            @(posedge clk_s); #1;
        end
    endtask

    task automatic load_pulse_b();
        @(negedge clk_s);
        load_b = 1'b1;
        @(posedge clk_s); #1;
        load_b = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        @(negedge clk_s);
        data_b = d; valid_b = 1'b1;
        @(posedge clk_s); #1;
        valid_b = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", match_a); end
        checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_a); end
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_a); end
        checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_a); end
        repeat (2) @(posedge clk_s);
        @(negedge clk_s);
        rstn_s = 1'b1;
        // EMPTY ignores bytes.
        send_a(8'h41);
        checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL empty_ignore_state: got %0d want 0", state_a); end
    endtask

    task automatic test_basic();
        logic [7:0] pat [4];
        logic [7:0] s   [6];
        logic [3:0] exp_r;
        logic [5:0] exp_m;
        int         exp_c [6];
        pat = '{8'h41, 8'h42, 8'h43, 8'h44};
        s   = '{8'h58, 8'h41, 8'h42, 8'h43, 8'h44, 8'h59};
        exp_r = 4'b1000;       // bit i = oREADY after load byte i
        exp_m = 6'b010000;     // bit i = oMATCH after stream byte i
        exp_c = '{0, 0, 0, 0, 1, 1};
        load_pulse_a(1'b0, 8'h00);
        checks++; if (state_a !== 2'd1) begin errors++; $display("FAIL basic_state_load: got %0d want 1", state_a); end
        for (int i = 0; i < 4; i++) begin
            send_a(pat[i]);
            checks++; if (ready_a !== exp_r[i]) begin errors++; $display("FAIL basic_ready[%0d]: got %b want %b", i, ready_a, exp_r[i]); end
            checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL basic_load_match[%0d]: got %b want 0", i, match_a); end
        end
        checks++; if (state_a !== 2'd2) begin errors++; $display("FAIL basic_state_scan: got %0d want 2", state_a); end
        for (int i = 0; i < 6; i++) begin
            send_a(s[i]);
            checks++; if (match_a !== exp_m[i]) begin errors++; $display("FAIL basic_match[%0d]: got %b want %b", i, match_a, exp_m[i]); end
            checks++; if (count_a !== 16'(exp_c[i])) begin errors++; $display("FAIL basic_count[%0d]: got %0d want %0d", i, count_a, exp_c[i]); end
        end
    endtask

    task automatic test_overlap();
        logic [5:0] exp_m;
        int         exp_c [6];
        exp_m = 6'b111000;
        exp_c = '{0, 0, 0, 1, 2, 3};
        load_pulse_a(1'b0, 8'h00);
        checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL overlap_count_clear: got %0d want 0", count_a); end
        repeat (4) send_a(8'h41);
        for (int i = 0; i < 6; i++) begin
            send_a(8'h41);
            checks++; if (match_a !== exp_m[i]) begin errors++; $display("FAIL overlap_match[%0d]: got %b want %b", i, match_a, exp_m[i]); end
            checks++; if (count_a !== 16'(exp_c[i])) begin errors++; $display("FAIL overlap_count[%0d]: got %0d want %0d", i, count_a, exp_c[i]); end
        end
    endtask

    task automatic test_idle_gaps();
        load_pulse_a(1'b0, 8'h00);
        send_a(8'h41); send_a(8'h42); send_a(8'h43); send_a(8'h44);
        send_a(8'h41);
        idle_a(2);
        send_a(8'h42);
        idle_a(1);
        send_a(8'h43);
        idle_a(3);
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL gap_idle_match: got %b want 0", match_a); end
        send_a(8'h44);
        checks++; if (match_a !== 1'b1) begin errors++; $display("FAIL gap_match: got %b want 1", match_a); end
        idle_a(1);
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL gap_pulse_width: got %b want 0", match_a); end
        checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL gap_count: got %0d want 1", count_a); end
    endtask

    task automatic test_reload();
        logic [7:0] pat [4];
        logic [3:0] exp_r;
        logic [3:0] exp_m;
        pat   = '{8'h50, 8'h51, 8'h52, 8'h53};
        exp_r = 4'b1000;
        exp_m = 4'b1000;
        // Count is 1 here. Reload with a byte in the same cycle; the byte is dropped.
        load_pulse_a(1'b1, 8'h41);
        checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL reload_count_clear: got %0d want 0", count_a); end
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reload_ready_clear: got %b want 0", ready_a); end
        for (int i = 0; i < 4; i++) begin
            send_a(pat[i]);
            checks++; if (ready_a !== exp_r[i]) begin errors++; $display("FAIL reload_ready[%0d]: got %b want %b", i, ready_a, exp_r[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            send_a(pat[i]);
            checks++; if (match_a !== exp_m[i]) begin errors++; $display("FAIL reload_match[%0d]: got %b want %b", i, match_a, exp_m[i]); end
        end
        checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL reload_count: got %0d want 1", count_a); end
    endtask

    task automatic test_saturation();
        int exp_c [5];
        exp_c = '{1, 2, 3, 3, 3};
        load_pulse_b();
        send_b(8'h41); send_b(8'h42);
        checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL sat_ready: got %b want 1", ready_b); end
        for (int i = 0; i < 5; i++) begin
            send_b(8'h41);
            checks++; if (match_b !== 1'b0) begin errors++; $display("FAIL sat_match_first[%0d]: got %b want 0", i, match_b); end
            send_b(8'h42);
            checks++; if (match_b !== 1'b1) begin errors++; $display("FAIL sat_match[%0d]: got %b want 1", i, match_b); end
            checks++; if (count_b !== 2'(exp_c[i])) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, count_b, exp_c[i]); end
        end
    endtask

    task automatic test_wildcard();
        logic       exp_wild;
        logic [7:0] s1 [4];
        logic [7:0] s2 [4];
`ifdef PATTERN_WILDCARD_EN
        exp_wild = 1'b1;
`else
        exp_wild = 1'b0;
`endif
        s1 = '{8'h41, 8'h5A, 8'h43, 8'h44};
        s2 = '{8'h41, 8'h3F, 8'h43, 8'h44};
        load_pulse_a(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) send_a(s2[i]);
        for (int i = 0; i < 4; i++) send_a(s1[i]);
        checks++; if (match_a !== exp_wild) begin errors++; $display("FAIL wild_match: got %b want %b", match_a, exp_wild); end
        for (int i = 0; i < 4; i++) send_a(s2[i]);
        checks++; if (match_a !== 1'b1) begin errors++; $display("FAIL wild_literal_match: got %b want 1", match_a); end
    endtask

    task automatic test_reset_midscan();
        // In SCAN with a nonzero count here; reset must act without a clock edge.
        @(negedge clk_s);
        #2 rstn_s = 1'b0;
        #1;
        checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL async_count: got %0d want 0", count_a); end
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL async_ready: got %b want 0", ready_a); end
        checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL async_state: got %0d want 0", state_a); end
        checks++; if (count_b !== 2'd0) begin errors++; $display("FAIL async_count_b: got %0d want 0", count_b); end
        @(negedge clk_s);
        rstn_s = 1'b1; load_a = 1'b1;
        @(posedge clk_s); #1;
        load_a = 1'b0;
        checks++; if (state_a !== 2'd1) begin errors++; $display("FAIL first_edge_state: got %0d want 1", state_a); end
    endtask

    task automatic test_reset_midload();
        logic [7:0] s [4];
        s = '{8'h41, 8'h42, 8'h43, 8'h44};
        load_pulse_a(1'b0, 8'h00);
        send_a(8'h41); send_a(8'h42);
        @(negedge clk_s);
        rstn_s = 1'b0;
        @(negedge clk_s);
        rstn_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_a(s[i]);
            checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL midload_match[%0d]: got %b want 0", i, match_a); end
        end
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL midload_ready: got %b want 0", ready_a); end
        checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL midload_state: got %0d want 0", state_a); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rstn_s = 1'b0;
        data_a = 8'h00; valid_a = 1'b0; load_a = 1'b0;
        data_b = 8'h00; valid_b = 1'b0; load_b = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_idle_gaps();
        test_reload();
        test_saturation();
        test_wildcard();
        test_reset_midscan();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/pattern_match.md
PATTERN_MATCH -- requirements
Module: pattern_match

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, number of pattern bytes (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of the match counter.
REQ-003 SHALL have port clk_s, input, 1, the single clock; all logic rises on posedge clk_s.
REQ-004 SHALL have port rstn_s, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port iDATA, input, 8, received byte from the UART receiver; meaningful only while iVALID=1.
REQ-006 SHALL have port iVALID, input, 1, single-cycle byte strobe (receiver done pulse).
REQ-007 SHALL have port iLOAD, input, 1, single-cycle command: the next PAT_LEN valid bytes form the new pattern.
REQ-008 SHALL have port oMATCH, output, 1, registered single-cycle pulse per pattern occurrence.
REQ-009 SHALL have port oCOUNT, output, CNT_W, number of matches since last load.
REQ-010 SHALL have port oREADY, output, 1, high while a complete pattern is held and scanning is active.

Function
REQ-011 SHALL implement FSM states EMPTY, LOAD, SCAN; reset state EMPTY.
REQ-012 EMPTY: SHALL ignore iVALID bytes; iLOAD=1 -> LOAD.
REQ-013 Entering LOAD (from any state) SHALL clear load index, window fill count, oCOUNT and oREADY in the same edge.
REQ-014 LOAD: each iVALID byte SHALL be written to pattern[index], index incremented; on the byte with index=PAT_LEN-1 -> SCAN, oREADY=1 on the following cycle.
REQ-015 iLOAD=1 and iVALID=1 in the same cycle SHALL discard that byte and (re)start LOAD with index 0; iLOAD during LOAD restarts the load.
REQ-016 SCAN: each iVALID byte SHALL shift into a PAT_LEN-byte window (newest at position PAT_LEN-1); fill count increments, saturating at PAT_LEN.
REQ-017 A match SHALL be declared when, including the byte just shifted, fill count = PAT_LEN and window equals pattern byte-for-byte in arrival order.
REQ-018 oMATCH SHALL assert exactly one cycle, on the cycle after the iVALID cycle carrying the final matching byte; latency 1 clock.
REQ-019 Overlapping occurrences SHALL each be reported (no window flush after a match).
REQ-020 oCOUNT SHALL increment by 1 in the same cycle oMATCH asserts and saturate at 2^CNT_W-1.
REQ-021 Cycles with iVALID=0 SHALL leave window, fill count and pattern unchanged; iDATA is don't-care then.
REQ-022 Bytes received in LOAD SHALL never produce oMATCH.

Reset
REQ-023 rstn_s=0 SHALL immediately force: state EMPTY, oMATCH=0, oCOUNT=0, oREADY=0, index=0, fill=0, pattern and window bytes 8'h00.
REQ-024 Reset asserted mid-load or mid-scan SHALL discard the partial pattern; after release the block needs a new iLOAD.
REQ-025 First edge after rstn_s deassertion SHALL be a normal functional edge.

Configuration
REQ-026 Macro PATTERN_WILDCARD_EN defined: a pattern byte of 8'h3F ('?') SHALL match any window byte at that position.
REQ-027 Macro PATTERN_WILDCARD_EN undefined: 8'h3F SHALL be compared literally; no wildcard logic synthesised.

Verification
REQ-028 Reset, iLOAD, bytes 41 42 43 44, then stream 58 41 42 43 44 59 -> oREADY=1 after 4th load byte, one oMATCH the cycle after 44 in stream, oCOUNT=1.
REQ-029 Pattern 41 41 41 41, stream six 41 -> three oMATCH pulses (after 4th, 5th, 6th byte), oCOUNT=3.
REQ-030 CNT_W=2, pattern 41 42, stream 41 42 repeated 5 times -> oCOUNT sequence 1,2,3,3,3, oMATCH pulses 5 times.
REQ-031 Load 41 42 43 44, iLOAD pulse with iVALID same cycle carrying 41, then bytes 50 51 52 53, stream 50 51 52 53 -> one match; oCOUNT cleared to 0 at reload, then 1.
REQ-032 rstn_s=0 after 2 load bytes, release, stream 41 42 43 44 -> no oMATCH, oREADY=0, state EMPTY.
REQ-033 PATTERN_WILDCARD_EN defined, pattern 41 3F 43 44, stream 41 5A 43 44 -> one oMATCH; undefined -> no oMATCH.
